// File: rtl/tvip_axi_read_slave_mem.sv
// AXI4 read-only slave backed by a word-addressed memory.
// Serves one AR burst at a time (no outstanding queue), one R beat per cycle.
// The memory has a backdoor write port and is never cleared by reset.
// Compile option: TVIP_AXI_READ_SLAVE_MEM_DECERR_EN -- when defined, beats whose
// word index falls outside the memory return DECERR with zero data; when
// undefined the word index wraps modulo DEPTH and the response is OKAY.
module tvip_axi_read_slave_mem #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    // Read address channel
    input  logic                       arvalid,
    output logic                       arready,
    input  logic [ID_WIDTH-1:0]        arid,
    input  logic [ADDR_WIDTH-1:0]      araddr,
    input  logic [7:0]                 arlen,
    input  logic [2:0]                 arsize,
    input  logic [1:0]                 arburst,
    // Read data channel
    output logic                       rvalid,
    input  logic                       rready,
    output logic [ID_WIDTH-1:0]        rid,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    // Backdoor memory write
    input  logic                       mem_we,
    input  logic [$clog2(DEPTH)-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]      mem_wdata
);

    localparam int OffsW = $clog2(DATA_WIDTH / 8);
    localparam int MemAw = $clog2(DEPTH);
    localparam logic [2:0] MaxSize = 3'(OffsW);

    localparam logic [1:0] BurstFixed = 2'd0;
    localparam logic [1:0] BurstIncr  = 2'd1;
    localparam logic [1:0] BurstWrap  = 2'd2;
    localparam logic [1:0] BurstRsvd  = 2'd3;

    localparam logic [1:0] RespOkay   = 2'd0;
    localparam logic [1:0] RespSlverr = 2'd2;
`ifdef TVIP_AXI_READ_SLAVE_MEM_DECERR_EN
    localparam logic [1:0] RespDecerr = 2'd3;
`endif

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Captured burst attributes and current beat position
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    // Registered R channel outputs
    logic                  rvalid_q, rvalid_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  rlast_q, rlast_d;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  load;
    logic                  ar_err;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic                  load_err;
    logic [7:0]            load_cnt;
    logic [MemAw-1:0]      mem_idx;

    // Address of the beat following 'addr' within a burst.
    function automatic logic [ADDR_WIDTH-1:0] next_beat_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [1:0]            burst,
        input logic [7:0]            len
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] aligned;
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        step    = ADDR_WIDTH'(1) << size;
        aligned = addr & ~(step - ADDR_WIDTH'(1));
        incr    = aligned + step;
        // Wrap window is the whole burst length in bytes
        mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BurstFixed: next_beat_addr = addr;
            BurstWrap:  next_beat_addr = (aligned & ~mask) | (incr & mask);
            default:    next_beat_addr = incr;
        endcase
    endfunction

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid_q && rready;
    // A new beat is loaded on the AR handshake and on every non-final R handshake
    assign load  = ar_hs || (r_hs && !rlast_q);

    // Burst request legality; illegal bursts still run their full length
    always_comb begin
        ar_err = 1'b0;
        if (arburst == BurstRsvd) begin
            ar_err = 1'b1;
        end
        if (arsize > MaxSize) begin
            ar_err = 1'b1;
        end
        if (arburst == BurstWrap &&
            !(arlen == 8'd1 || arlen == 8'd3 || arlen == 8'd7 || arlen == 8'd15)) begin
            ar_err = 1'b1;
        end
    end

    // State register
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (arvalid) state_d = StBurst;
            StBurst: if (r_hs && rlast_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        arready = (state_q == StIdle);
    end

    // Next beat selection and data fetch
    always_comb begin
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;

        load_addr = next_beat_addr(addr_q, size_q, burst_q, len_q);
        load_err  = err_q;
        load_cnt  = cnt_q + 8'd1;

        if (ar_hs) begin
            id_d      = arid;
            len_d     = arlen;
            size_d    = arsize;
            burst_d   = arburst;
            err_d     = ar_err;
            load_addr = araddr;
            load_err  = ar_err;
            load_cnt  = 8'd0;
        end

        mem_idx = MemAw'(load_addr >> OffsW);

        if (load) begin
            addr_d   = load_addr;
            cnt_d    = load_cnt;
            rvalid_d = 1'b1;
            rid_d    = id_d;
            rlast_d  = (load_cnt == len_d);
            if (load_err) begin
                rresp_d = RespSlverr;
                rdata_d = '0;
            end else begin
                rresp_d = RespOkay;
                // Combinational read sees pre-edge contents, so a same-cycle
                // backdoor write to this word is not visible on this beat
                rdata_d = mem_q[mem_idx];
`ifdef TVIP_AXI_READ_SLAVE_MEM_DECERR_EN
                if (((load_addr >> OffsW) >> MemAw) != '0) begin
                    rresp_d = RespDecerr;
                    rdata_d = '0;
                end
`endif
            end
        end else if (r_hs) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
        end
    end

    // Burst context and R channel registers
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= BurstIncr;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
            rlast_q  <= 1'b0;
        end else begin
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    // Backdoor write port; memory contents survive reset
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign rvalid = rvalid_q;
    assign rid    = rid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;

endmodule

// File: tb/tb_tvip_axi_read_slave_mem.sv
// Directed self-checking bench for tvip_axi_read_slave_mem (default parameters).
// Honours TVIP_AXI_READ_SLAVE_MEM_DECERR_EN for the out-of-range expectation.
module tb_tvip_axi_read_slave_mem;

    localparam logic [31:0] A0   = 32'hA0A0_A0A0;
    localparam logic [31:0] A1   = 32'hA1A1_A1A1;
    localparam logic [31:0] A2   = 32'hA2A2_A2A2;
    localparam logic [31:0] A3   = 32'hA3A3_A3A3;
    localparam logic [31:0] M0   = 32'h1234_5678;
    localparam logic [31:0] MNEW = 32'hCAFE_F00D;

    logic        aclk;
    logic        areset_n;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    tvip_axi_read_slave_mem #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (256)
    ) u_dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .arvalid   (arvalid),
        .arready   (arready),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts and ends just after a rising edge.
    task automatic mem_write(input logic [7:0] idx, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_addr  = idx;
        mem_wdata = data;
        @(posedge aclk);
        #1;
        mem_we = 1'b0;
    endtask

    // Presents an AR request for exactly one edge; arready must be high.
    task automatic issue_ar(input string tag, input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        arvalid = 1'b1;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        @(negedge aclk);
        check_eq({tag, ".arready"}, 64'(arready), 64'd1);
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
    endtask

    // Checks the beat presented this cycle, then lets the edge consume it.
    task automatic expect_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                               input logic [1:0] resp, input logic last);
        @(negedge aclk);
        check_eq({tag, ".rvalid"}, 64'(rvalid), 64'd1);
        check_eq({tag, ".rid"},    64'(rid),    64'(id));
        check_eq({tag, ".rdata"},  64'(rdata),  64'(data));
        check_eq({tag, ".rresp"},  64'(rresp),  64'(resp));
        check_eq({tag, ".rlast"},  64'(rlast),  64'(last));
        @(posedge aclk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        @(negedge aclk);
        check_eq({tag, ".arready"}, 64'(arready), 64'd1);
        check_eq({tag, ".rvalid"},  64'(rvalid),  64'd0);
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset_n  = 1'b1;
        arvalid   = 1'b0;
        arid      = '0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;
        rready    = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        #2 areset_n = 1'b0;
        #1;
        check_eq("rst.arready", 64'(arready), 64'd1);
        check_eq("rst.rvalid",  64'(rvalid),  64'd0);
        check_eq("rst.rlast",   64'(rlast),   64'd0);
        check_eq("rst.rresp",   64'(rresp),   64'd0);
        check_eq("rst.rid",     64'(rid),     64'd0);
        check_eq("rst.rdata",   64'(rdata),   64'd0);

        mem_write(8'd0, M0);
        mem_write(8'd4, A0);
        mem_write(8'd5, A1);
        mem_write(8'd6, A2);
        mem_write(8'd7, A3);
        areset_n = 1'b1;
        @(posedge aclk);
        #1;

        // INCR word burst, back-to-back beats
        issue_ar("incr", 4'h1, 32'h10, 8'd3, 3'd2, 2'd1);
        expect_beat("incr.b0", 4'h1, A0, 2'd0, 1'b0);
        expect_beat("incr.b1", 4'h1, A1, 2'd0, 1'b0);
        expect_beat("incr.b2", 4'h1, A2, 2'd0, 1'b0);
        expect_beat("incr.b3", 4'h1, A3, 2'd0, 1'b1);
        check_idle("incr.end");

        // WRAP: 0x18,0x1C,0x10,0x14
        issue_ar("wrap", 4'h5, 32'h18, 8'd3, 3'd2, 2'd2);
        expect_beat("wrap.b0", 4'h5, A2, 2'd0, 1'b0);
        expect_beat("wrap.b1", 4'h5, A3, 2'd0, 1'b0);
        expect_beat("wrap.b2", 4'h5, A0, 2'd0, 1'b0);
        expect_beat("wrap.b3", 4'h5, A1, 2'd0, 1'b1);
        check_idle("wrap.end");

        // FIXED repeats the start word
        issue_ar("fixed", 4'h2, 32'h14, 8'd2, 3'd2, 2'd0);
        expect_beat("fixed.b0", 4'h2, A1, 2'd0, 1'b0);
        expect_beat("fixed.b1", 4'h2, A1, 2'd0, 1'b0);
        expect_beat("fixed.b2", 4'h2, A1, 2'd0, 1'b1);
        check_idle("fixed.end");

        // Halfword INCR: 0x10,0x12,0x14,0x16 -> words 4,4,5,5
        issue_ar("half", 4'h6, 32'h10, 8'd3, 3'd1, 2'd1);
        expect_beat("half.b0", 4'h6, A0, 2'd0, 1'b0);
        expect_beat("half.b1", 4'h6, A0, 2'd0, 1'b0);
        expect_beat("half.b2", 4'h6, A1, 2'd0, 1'b0);
        expect_beat("half.b3", 4'h6, A1, 2'd1 == 2'd1 ? 2'd0 : 2'd0, 1'b1);
        check_idle("half.end");

        // Backpressure on beat 0; AR arriving mid-burst must wait
        rready = 1'b0;
        issue_ar("stall", 4'h3, 32'h10, 8'd1, 3'd2, 2'd1);
        @(negedge aclk);
        check_eq("stall.rvalid",  64'(rvalid),  64'd1);
        check_eq("stall.rdata",   64'(rdata),   64'(A0));
        check_eq("stall.arready", 64'(arready), 64'd0);
        arvalid = 1'b1;
        araddr  = 32'h18;
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk);
            #1;
            @(negedge aclk);
            check_eq("stall.hold_rvalid", 64'(rvalid),  64'd1);
            check_eq("stall.hold_rdata",  64'(rdata),   64'(A0));
            check_eq("stall.hold_rlast",  64'(rlast),   64'd0);
            check_eq("stall.hold_arrdy",  64'(arready), 64'd0);
        end
        arvalid = 1'b0;
        rready  = 1'b1;
        @(posedge aclk);
        #1;
        expect_beat("stall.b1", 4'h3, A1, 2'd0, 1'b1);
        check_idle("stall.end");

        // Reserved burst type -> SLVERR, full length
        issue_ar("rsvd", 4'h7, 32'h10, 8'd2, 3'd2, 2'd3);
        expect_beat("rsvd.b0", 4'h7, 32'd0, 2'd2, 1'b0);
        expect_beat("rsvd.b1", 4'h7, 32'd0, 2'd2, 1'b0);
        expect_beat("rsvd.b2", 4'h7, 32'd0, 2'd2, 1'b1);
        check_idle("rsvd.end");

        // Oversized beat and bad wrap length -> SLVERR
        issue_ar("bigsz", 4'h8, 32'h10, 8'd0, 3'd3, 2'd1);
        expect_beat("bigsz.b0", 4'h8, 32'd0, 2'd2, 1'b1);
        issue_ar("wraplen", 4'h9, 32'h10, 8'd2, 3'd2, 2'd2);
        expect_beat("wraplen.b0", 4'h9, 32'd0, 2'd2, 1'b0);
        expect_beat("wraplen.b1", 4'h9, 32'd0, 2'd2, 1'b0);
        expect_beat("wraplen.b2", 4'h9, 32'd0, 2'd2, 1'b1);
        check_idle("wraplen.end");

        // Word index 0x100 is past the 256-word memory
`ifdef TVIP_AXI_READ_SLAVE_MEM_DECERR_EN
        issue_ar("oob", 4'hA, 32'h400, 8'd0, 3'd2, 2'd1);
        expect_beat("oob.b0", 4'hA, 32'd0, 2'd3, 1'b1);
`else
        issue_ar("oob", 4'hA, 32'h400, 8'd0, 3'd2, 2'd1);
        expect_beat("oob.b0", 4'hA, M0, 2'd0, 1'b1);
`endif
        check_idle("oob.end");

        // Backdoor write on the load edge: beat sees the old word
        mem_we    = 1'b1;
        mem_addr  = 8'd0;
        mem_wdata = MNEW;
        issue_ar("wr_old", 4'hB, 32'h0, 8'd0, 3'd2, 2'd1);
        mem_we = 1'b0;
        expect_beat("wr_old.b0", 4'hB, M0, 2'd0, 1'b1);
        issue_ar("wr_new", 4'hB, 32'h0, 8'd0, 3'd2, 2'd1);
        expect_beat("wr_new.b0", 4'hB, MNEW, 2'd0, 1'b1);

        // Reset during beat 2 aborts at once; memory survives
        issue_ar("abort", 4'hC, 32'h10, 8'd7, 3'd2, 2'd1);
        expect_beat("abort.b0", 4'hC, A0, 2'd0, 1'b0);
        expect_beat("abort.b1", 4'hC, A1, 2'd0, 1'b0);
        @(negedge aclk);
        areset_n = 1'b0;
        #1;
        check_eq("abort.rvalid",  64'(rvalid),  64'd0);
        check_eq("abort.arready", 64'(arready), 64'd1);
        check_eq("abort.rlast",   64'(rlast),   64'd0);
        #2 areset_n = 1'b1;
        @(posedge aclk);
        #1;
        issue_ar("after", 4'hD, 32'h14, 8'd1, 3'd2, 2'd1);
        expect_beat("after.b0", 4'hD, A1, 2'd0, 1'b0);
        expect_beat("after.b1", 4'hD, A2, 2'd0, 1'b1);
        check_idle("after.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tvip_axi_read_slave_mem.md
TVIP_AXI_READ_SLAVE_MEM -- requirements
Module: tvip_axi_read_slave_mem

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, ARID/RID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, ARADDR width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, RDATA width (8..1024, power of 2).
REQ-004 SHALL have parameter DEPTH, default 256, memory depth in DATA_WIDTH words (power of 2).
REQ-005 SHALL have a single clock and an asynchronous, active-low reset; no other clock or reset.
REQ-006 aclk  input  1  clock; all logic samples on the rising edge.
REQ-007 areset_n  input  1  asynchronous active-low reset.
REQ-008 arvalid  input  1  read address valid.
REQ-009 arready  output  1  read address ready.
REQ-010 arid  input  ID_WIDTH  transaction ID.
REQ-011 araddr  input  ADDR_WIDTH  byte start address.
REQ-012 arlen  input  8  beats minus 1.
REQ-013 arsize  input  3  log2 bytes per beat.
REQ-014 arburst  input  2  FIXED=0, INCR=1, WRAP=2, reserved=3.
REQ-015 rvalid  output  1  read data valid.
REQ-016 rready  input  1  read data ready.
REQ-017 rid  output  ID_WIDTH  echoed arid.
REQ-018 rdata  output  DATA_WIDTH  full word at beat address.
REQ-019 rresp  output  2  OKAY=0, SLVERR=2, DECERR=3.
REQ-020 rlast  output  1  final beat.
REQ-021 mem_we  input  1  backdoor word write enable.
REQ-022 mem_addr  input  log2(DEPTH)  backdoor word index.
REQ-023 mem_wdata  input  DATA_WIDTH  backdoor write data.

Function
REQ-024 FSM states are IDLE and BURST; arready SHALL be 1 exactly when in IDLE.
REQ-025 AR handshake (arvalid&&arready) SHALL capture id/addr/len/size/burst and enter BURST.
REQ-026 The first rvalid SHALL assert the cycle after the AR handshake (latency 1).
REQ-027 rid/rdata/rresp/rlast SHALL stay stable while rvalid&&!rready.
REQ-028 Each R handshake SHALL load the next beat, so rvalid stays 1 back-to-back (one beat per cycle at rready=1).
REQ-029 Beat N address: FIXED=start; INCR=start aligned to 2^size, plus N*2^size; WRAP=INCR, wrapped within the (len+1)*2^size-aligned boundary.
REQ-030 Word index = beat address >> log2(DATA_WIDTH/8), modulo DEPTH unless REQ-044 applies.
REQ-031 rlast SHALL be 1 on beat len only; R handshake with rlast SHALL return to IDLE, arready=1 next cycle.
REQ-032 arburst=3, arsize>log2(DATA_WIDTH/8), or WRAP with len not in {1,3,7,15} SHALL give rresp=SLVERR, rdata=0, still len+1 beats.
REQ-033 mem_we SHALL write mem[mem_addr] at the clock edge; a beat loaded in that cycle from the same word SHALL return old data.
REQ-034 ARVALID arriving during BURST SHALL wait (arready=0); no outstanding queue.

Reset
REQ-035 On areset_n=0: FSM=IDLE, arready=1, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0.
REQ-036 Reset mid-burst SHALL abort the burst immediately; memory contents SHALL NOT be reset.

Configuration
REQ-037 Macro TVIP_AXI_READ_SLAVE_MEM_DECERR_EN SHALL be the only compile option.
REQ-044 Defined: beats whose word index >= DEPTH SHALL return rresp=DECERR, rdata=0; undefined: index wraps modulo DEPTH, rresp=OKAY.
REQ-045 SLVERR (REQ-032) SHALL take precedence over DECERR.

Verification
REQ-046 mem[4..7]=A0..A3; INCR araddr=0x10 len=3 size=2, rready=1 -> A0..A3 on 4 consecutive cycles, rlast on A3, OKAY.
REQ-047 WRAP araddr=0x18 len=3 size=2 -> words 6,7,4,5; rid equals arid=0x5.
REQ-048 INCR len=1, rready low for 3 cycles at beat 0 -> rdata/rlast held, beat 1 follows, arready=1 after rlast handshake.
REQ-049 arburst=3 len=2 -> 3 beats SLVERR, rdata=0, rlast on third.
REQ-050 DEPTH=256, araddr=0x400 len=0: macro on -> DECERR; off -> mem[0], OKAY.
REQ-051 areset_n low during beat 2 of len=7 -> rvalid=0, arready=1 immediately; next burst returns correct data.
